// File: rtl/alu_op_fsm_pkg.sv
// Shared types for the three-register ALU instruction sequencer.
// Opcodes, ALU modes and fault codes used by the FSM and its bus.
package alu_op_fsm_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_MUL  = 2'b01,
    MODE_DIV  = 2'b10,
    MODE_NAND = 2'b11
  } alu_mode_t;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_DIV0    = 2'b01,
    FLT_TIMEOUT = 2'b10,
    FLT_ILLEGAL = 2'b11
  } alu_fault_t;

  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return (op == OP_ADD) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_NAND);
  endfunction

  function automatic alu_mode_t op_mode(
    input logic [3:0] op
  );
    alu_mode_t m;
    m = MODE_ADD;
    unique case (1'b1)
      (op == OP_MUL):  m = MODE_MUL;
      (op == OP_DIV):  m = MODE_DIV;
      (op == OP_NAND): m = MODE_NAND;
      default:         m = MODE_ADD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_op_fsm_if.sv
// Request/acknowledge bus between the sequencer and a
// variable-latency ALU.
interface alu_op_fsm_if #(
  parameter int WIDTH = 32
);
  import alu_op_fsm_pkg::*;

  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  alu_mode_t        alu_mode;
  logic             alu_req;
  logic             alu_ack;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output alu_x,
    output alu_y,
    output alu_mode,
    output alu_req,
    input  alu_ack,
    input  alu_result
  );

  modport slave (
    input  alu_x,
    input  alu_y,
    input  alu_mode,
    input  alu_req,
    output alu_ack,
    output alu_result
  );
endinterface

// File: rtl/alu_wait_timer.sv
// Clear/enable wait counter; expired flags the last allowed
// cycle without an acknowledge.
module alu_wait_timer #(
  parameter int MAX_WAIT   = 16,
  parameter int WAIT_CNT_W = 5
) (
  input  logic clk,
  input  logic init_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [WAIT_CNT_W-1:0] cnt;

  localparam logic [WAIT_CNT_W-1:0] LAST =
    WAIT_CNT_W'(MAX_WAIT - 1);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);
endmodule

// File: rtl/alu_op_fsm.sv
// Single FSM sequencing add/mul/div/nand through the register
// file and a handshaked ALU, with div0/timeout/illegal faults.
module alu_op_fsm
  import alu_op_fsm_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 3,
  parameter int MAX_WAIT   = 16,
  parameter int WAIT_CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  init_n,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [REG_ADDR_W-1:0] reg_a,
  input  logic [REG_ADDR_W-1:0] reg_b,
  input  logic [REG_ADDR_W-1:0] reg_c,
  input  logic [WIDTH-1:0]      reg_rdata,
  output logic [REG_ADDR_W-1:0] reg_sel,
  output logic                  reg_we,
  output logic [WIDTH-1:0]      reg_wdata,
  alu_op_fsm_if.master          alu,
  output logic                  busy,
  output logic                  finished,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL_B, S_SEL_C, S_LATCH_C,
    S_ALU_REQ, S_ALU_WAIT, S_WRITE_A, S_DONE
  } state_t;

  state_t                state, state_nx;
  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] a_q, b_q, c_q;
  logic                  set_flt;
  alu_fault_t            flt_nx;
  logic                  in_alu;
  logic                  tmr_exp;

  assign in_alu = (state == S_ALU_REQ) ||
                  (state == S_ALU_WAIT);

  alu_wait_timer #(
    .MAX_WAIT   (MAX_WAIT),
    .WAIT_CNT_W (WAIT_CNT_W)
  ) u_timer (
    .clk     (clk),
    .init_n  (init_n),
    .clr     (state == S_LATCH_C),
    .en      (in_alu && !alu.alu_ack),
    .expired (tmr_exp)
  );

  always_comb begin
    state_nx = state;
    set_flt  = 1'b0;
    flt_nx   = FLT_NONE;
    unique case (state)
      S_IDLE: begin
        if (start && !op_legal(opcode)) begin
          state_nx = S_DONE;
          set_flt  = 1'b1;
          flt_nx   = FLT_ILLEGAL;
        end else if (start) begin
          state_nx = S_SEL_B;
        end
      end
      S_SEL_B: state_nx = S_SEL_C;
      S_SEL_C: state_nx = S_LATCH_C;
      S_LATCH_C: begin
        if (op_q == OP_DIV && reg_rdata == '0) begin
          state_nx = S_DONE;
          set_flt  = 1'b1;
          flt_nx   = FLT_DIV0;
        end else begin
          state_nx = S_ALU_REQ;
        end
      end
      S_ALU_REQ, S_ALU_WAIT: begin
        // a late ack in the timeout cycle still wins
        if (alu.alu_ack) begin
          state_nx = S_WRITE_A;
        end else if (tmr_exp) begin
          state_nx = S_DONE;
          set_flt  = 1'b1;
          flt_nx   = FLT_TIMEOUT;
        end else begin
          state_nx = S_ALU_WAIT;
        end
      end
      S_WRITE_A: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    reg_sel = '0;
    unique case (state)
      S_SEL_B:   reg_sel = b_q;
      S_SEL_C:   reg_sel = c_q;
      S_WRITE_A: reg_sel = a_q;
      default:   reg_sel = '0;
    endcase
  end

  assign reg_we       = (state == S_WRITE_A);
  assign busy         = (state != S_IDLE);
  assign finished     = (state == S_DONE);
  assign alu.alu_req  = in_alu;
  assign alu.alu_mode = in_alu ? op_mode(op_q)
                               : MODE_ADD;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      alu.alu_x  <= '0;
      alu.alu_y  <= '0;
      reg_wdata  <= '0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        op_q       <= opcode;
        a_q        <= reg_a;
        b_q        <= reg_b;
        c_q        <= reg_c;
        fault      <= 1'b0;
        fault_code <= FLT_NONE;
      end
      if (state == S_SEL_C) alu.alu_x <= reg_rdata;
      if (state == S_LATCH_C) alu.alu_y <= reg_rdata;
      if (in_alu && alu.alu_ack)
        reg_wdata <= alu.alu_result;
      if (set_flt) begin
        fault      <= 1'b1;
        fault_code <= flt_nx;
      end
    end
  end

endmodule

// File: doc/alu_op_fsm.md
Name: alu_op_fsm

Overview:
- Parametrised successor to the per-instruction adder sequencer in the control unit.
- A single FSM executes all four three-register ALU instructions: add (0011), mul (0100), div (0101), nand (0110).
- Talks to a variable-latency ALU through a req/ack handshake, detects divide-by-zero and ALU timeout, and reports a fault instead of writing register A.
- Sits between control_unit (start/finished) and the register file and ALU.

Parameters:
- WIDTH, 32, data word width.
- REG_ADDR_W, 3, register-select width.
- MAX_WAIT, 16, ALU wait cycles before timeout fault (must be at least 1).
- WAIT_CNT_W, 5, counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock
- init_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin instruction
- opcode  in  4  instruction opcode, sampled at start
- reg_a  in  REG_ADDR_W  destination register, sampled at start
- reg_b  in  REG_ADDR_W  operand x register, sampled at start
- reg_c  in  REG_ADDR_W  operand y register, sampled at start
- reg_rdata  in  WIDTH  register-file read data; valid one cycle after reg_sel
- reg_sel  out  REG_ADDR_W  register select
- reg_we  out  1  register write strobe
- reg_wdata  out  WIDTH  register write data
- alu_x  out  WIDTH  ALU operand x (registered)
- alu_y  out  WIDTH  ALU operand y (registered)
- alu_mode  out  2  00 add, 01 mul, 10 div, 11 nand
- alu_req  out  1  level request; held until alu_ack
- alu_ack  in  1  ALU result valid
- alu_result  in  WIDTH  ALU result
- busy  out  1  instruction in progress
- finished  out  1  one-cycle pulse at completion
- fault  out  1  sticky; set on error, cleared by the next accepted start
- fault_code  out  2  00 none, 01 div-by-zero, 10 timeout, 11 illegal opcode

Behaviour:
- Reset (init_n low, asynchronous): state IDLE; all outputs 0, including alu_x, alu_y, reg_sel, reg_wdata, fault and fault_code.
- IDLE:
  - start=1 latches opcode and reg_a/b/c, clears fault and fault_code.
  - Opcode not in {3,4,5,6}: go to DONE with fault=1, code 11.
  - Otherwise go to SEL_B.
  - start while busy is ignored.
- SEL_B: reg_sel=b. Next state SEL_C.
- SEL_C: reg_sel=c; alu_x <= reg_rdata. Next state LATCH_C.
- LATCH_C: alu_y <= reg_rdata.
  - Div with reg_rdata==0: go to DONE with fault=1, code 01. No ALU request is issued.
  - Otherwise go to ALU_REQ.
- ALU_REQ / ALU_WAIT:
  - alu_req=1 and alu_mode valid from ALU_REQ until the ack cycle.
  - The wait counter clears on entry and increments each cycle without ack.
  - alu_ack=1: capture alu_result into reg_wdata, go to WRITE_A.
  - Counter reaches MAX_WAIT without ack: go to DONE with fault=1, code 10; alu_req drops.
  - An ack arriving in the same cycle as the timeout wins (no fault).
- WRITE_A: reg_sel=a, reg_we=1 for exactly one cycle. Next state DONE.
- DONE: finished=1 for one cycle. Next state IDLE.
- busy=1 in every state except IDLE.
- Latency, zero-wait ALU (ack in the first req cycle): start to finished is 6 cycles.
- Arithmetic is done in the ALU modulo 2^WIDTH; this block does no arithmetic except the zero compare.
- alu_x and alu_y hold their last values when idle.
- reg_a equal to reg_b or reg_c is legal; the write happens after both reads.
- init_n asserted mid-instruction aborts immediately; no write and no finished pulse.

Decomposition:
- BusTypes package gains:
  - alu_mode_t enum;
  - alu_fault_t enum (NONE, DIV0, TIMEOUT, ILLEGAL);
  - opcode constants OP_ADD, OP_MUL, OP_DIV, OP_NAND.
- FSM state enum stays local to the module.
- One sub-module, alu_wait_timer: clear/enable counter with an expired flag, parametrised by MAX_WAIT and WAIT_CNT_W.

Test Plan:
- r1=7, r2=5; start add (a=3, b=1, c=2); ALU acks in the first cycle -> r3=12, finished at cycle 6, fault=0.
- r1=0xFFFFFFFF, r2=0xFFFFFFFF; nand a=0, b=1, c=2 -> reg_we once with wdata=0, alu_mode=11.
- div with r2=0 -> fault=1, code 01, alu_req never asserted, reg_we never asserted, finished pulses.
- mul; ALU acks after 5 cycles -> alu_req held exactly through ack, write occurs, total latency 10 cycles.
- MAX_WAIT=16; alu_ack tied 0 -> fault code 10 after 16 wait cycles, no write. Then a new start clears fault.
- Opcode 0111 -> code 11, finished pulses. Separately, init_n pulsed low during ALU_WAIT -> outputs 0 asynchronously and the FSM returns to IDLE.
